mac_job_scheduler: RTL and testbench
====================================

Name: mac_job_scheduler

Overview:
Queues matrix-multiply jobs from the host/testbench side and sequences them one at a time through the MAC engine's valid/ready handshake. It holds each job's three SRAM base addresses stable for the whole run, detects completion from the MAC ready signal, and reports per-job completion tags. A watchdog flags a stuck job. It sits between the top-level control and the MAC engine.

Parameters:
ADDR_W, 12, width of SRAM addresses (matches SRAM address range)
TAG_W, 4, width of the job tag returned on completion
DEPTH, 4, job FIFO entries (power of two, >=2)
TIMEOUT, 65535, max cycles from MAC-busy to MAC-ready before error
DRAIN, 2, cycles addresses stay held after MAC ready re-asserts

Ports:
clk  in  1  clock, all logic posedge
reset_n  in  1  asynchronous active-low reset
job_valid  in  1  host offers a job
job_ready  out  1  FIFO not full; push when job_valid&&job_ready
job_input_base  in  ADDR_W  input matrix base address
job_weight_base  in  ADDR_W  weight matrix base address
job_result_base  in  ADDR_W  result write start address
job_tag  in  TAG_W  opaque job id
mac_valid  out  1  start request to MAC
mac_ready  in  1  MAC idle/ready
mac_input_base  out  ADDR_W  held input base
mac_weight_base  out  ADDR_W  held weight base
mac_result_base  out  ADDR_W  held result base
done_valid  out  1  one-cycle pulse: job finished (or timed out)
done_tag  out  TAG_W  tag of finished job, valid with done_valid
err_timeout  out  1  sticky; set on watchdog expiry, cleared only by reset
busy  out  1  state != IDLE or FIFO non-empty
queue_level  out  clog2(DEPTH)+1  FIFO occupancy
jobs_completed  out  16  count of successful jobs, wraps at 65535->0

Behaviour:
- Reset (async, reset_n low): state IDLE, FIFO empty, all outputs 0 except job_ready=1; mac_* base outputs 0; err_timeout 0; counters 0.
- FIFO: DEPTH entries of {input,weight,result,tag}; push and pop in same cycle allowed (level unchanged); push when full ignored (job_ready=0); pop only in IDLE->ISSUE transition.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN, REPORT.
- IDLE: if FIFO non-empty and mac_ready=1, pop head into hold registers (mac_*_base update same edge), go ISSUE. If mac_ready=0 stay IDLE.
- ISSUE: mac_valid=1 for exactly this state; next WAIT_BUSY. Bases already stable one cycle before mac_valid.
- WAIT_BUSY: mac_valid=0; on mac_ready=0 go WAIT_DONE, watchdog cleared to 0. If mac_ready stays 1 for 4 cycles, return to ISSUE (retry; the MAC must not miss the start).
- WAIT_DONE: watchdog increments each cycle; mac_ready=1 -> DRAIN, counter loaded DRAIN-1. Watchdog == TIMEOUT -> set err_timeout, go REPORT with failure (jobs_completed not incremented).
- DRAIN: hold bases; count down; at 0 -> REPORT.
- REPORT: done_valid=1, done_tag=held tag, jobs_completed += 1 on success; next IDLE. Earliest next mac_valid is 2 cycles after REPORT (IDLE, ISSUE).
- mac_*_base change only on pop; never change between ISSUE and REPORT inclusive.
- Latency: job pushed into empty FIFO with MAC idle -> mac_valid 2 cycles after push edge.
- reset_n asserted mid-job: FSM and FIFO cleared immediately; in-flight job lost, no done_valid.
- Tag/address widths truncate nothing; all arithmetic on counters unsigned, wrap on overflow.

Test Plan:
- Single job {in=0x000, wt=0x100, res=0x200, tag=3} into idle system with MAC model 10 busy cycles -> mac_valid one cycle 2 cycles after push; done_valid with done_tag=3 at ready-rise + DRAIN + 1; jobs_completed=1.
- Push 5 jobs back-to-back with DEPTH=4 while MAC busy -> job_ready low at level 4, 5th held by host; all 5 complete in push order, tags 0..4, jobs_completed=5.
- Simultaneous push and pop at level 2 -> queue_level stays 2; popped entry is oldest.
- MAC model never drops mac_ready after mac_valid -> mac_valid re-issued every 5 cycles, no done_valid.
- MAC model holds mac_ready=0 with TIMEOUT=100 -> err_timeout=1 after 100 WAIT_DONE cycles, done_valid pulse with tag, jobs_completed unchanged, next job proceeds.
- reset_n low during WAIT_DONE with 2 jobs queued -> all outputs reset values immediately, queue_level=0, no done_valid after release.

Source files
------------

// File: rtl/mac_job_scheduler_if.sv
// mac_job_scheduler_if: job queue, MAC handshake and completion signals of the job scheduler
interface mac_job_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int TAG_W  = 4
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_input_base;
  logic [ADDR_W-1:0] job_weight_base;
  logic [ADDR_W-1:0] job_result_base;
  logic [TAG_W-1:0]  job_tag;
  logic              mac_valid;
  logic              mac_ready;
  logic [ADDR_W-1:0] mac_input_base;
  logic [ADDR_W-1:0] mac_weight_base;
  logic [ADDR_W-1:0] mac_result_base;
  logic              done_valid;
  logic [TAG_W-1:0]  done_tag;
  modport master (
    output job_valid, job_input_base, job_weight_base, job_result_base, job_tag, mac_ready,
    input  job_ready, mac_valid, mac_input_base, mac_weight_base, mac_result_base, done_valid, done_tag
  );
  modport slave (
    input  job_valid, job_input_base, job_weight_base, job_result_base, job_tag, mac_ready,
    output job_ready, mac_valid, mac_input_base, mac_weight_base, mac_result_base, done_valid, done_tag
  );
endinterface

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: queues matrix-multiply jobs and runs them one at a time through the MAC handshake
module mac_job_scheduler #(
  parameter int ADDR_W  = 12,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535,
  parameter int DRAIN   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mac_job_scheduler_if.slave     bus,
  output logic                   err_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_level,
  output logic [15:0]            jobs_completed
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DRAIN > 4 ? DRAIN : 4);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DRAIN, S_REPORT} state_t;
  state_t            state, nxt;
  logic [ADDR_W-1:0] in_mem [DEPTH];
  logic [ADDR_W-1:0] wt_mem [DEPTH];
  logic [ADDR_W-1:0] res_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WW-1:0]     wd, wd_nxt;
  logic [TAG_W-1:0]  tag_q;
  logic              push, pop, timeout_hit, fail_q;
  assign bus.job_ready  = count != (AW+1)'(DEPTH);
  assign push           = bus.job_valid && bus.job_ready;
  assign pop            = state == S_IDLE && count != '0 && bus.mac_ready;
  assign bus.done_valid = state == S_REPORT;
  assign bus.done_tag   = tag_q;
  assign busy           = state != S_IDLE || count != '0;
  assign queue_level    = count;
  always_ff @(posedge clk) begin
    if (push) begin
      in_mem[wr_ptr]  <= bus.job_input_base;
      wt_mem[wr_ptr]  <= bus.job_weight_base;
      res_mem[wr_ptr] <= bus.job_result_base;
      tag_mem[wr_ptr] <= bus.job_tag;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // WAIT_BUSY reuses cnt as a retry counter: four ready cycles without the MAC going busy re-issues the start
  always_comb begin
    nxt         = state;
    cnt_nxt     = cnt;
    wd_nxt      = wd;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:      nxt = pop ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        nxt     = S_WAIT_BUSY;
        cnt_nxt = '0;
      end
      S_WAIT_BUSY:
        if (!bus.mac_ready) begin
          nxt    = S_WAIT_DONE;
          wd_nxt = '0;
        end else if (cnt == CW'(3)) nxt = S_ISSUE;
        else cnt_nxt = cnt + 1'b1;
      S_WAIT_DONE:
        if (bus.mac_ready) begin
          nxt     = S_DRAIN;
          cnt_nxt = CW'(DRAIN - 1);
        end else if (wd == WW'(TIMEOUT)) begin
          nxt         = S_REPORT;
          timeout_hit = 1'b1;
        end else wd_nxt = wd + 1'b1;
      S_DRAIN:
        if (cnt == '0) nxt = S_REPORT;
        else cnt_nxt = cnt - 1'b1;
      S_REPORT:    nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end
  // mac_valid is registered so the popped bases lead it by a full cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      wd                  <= '0;
      fail_q              <= 1'b0;
      err_timeout         <= 1'b0;
      jobs_completed      <= '0;
      tag_q               <= '0;
      bus.mac_valid       <= 1'b0;
      bus.mac_input_base  <= '0;
      bus.mac_weight_base <= '0;
      bus.mac_result_base <= '0;
    end else begin
      state         <= nxt;
      cnt           <= cnt_nxt;
      wd            <= wd_nxt;
      bus.mac_valid <= state == S_ISSUE;
      if (pop) begin
        bus.mac_input_base  <= in_mem[rd_ptr];
        bus.mac_weight_base <= wt_mem[rd_ptr];
        bus.mac_result_base <= res_mem[rd_ptr];
        tag_q               <= tag_mem[rd_ptr];
        fail_q              <= 1'b0;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
        fail_q      <= 1'b1;
      end
      if (state == S_REPORT && !fail_q) jobs_completed <= jobs_completed + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb_mac_job_scheduler: directed table vectors plus multi-cycle corner sequences against a simple MAC model
module tb_mac_job_scheduler;
  localparam int ADDR_W = 12, TAG_W = 4, DEPTH = 4, TIMEOUT = 100, DRAIN = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_timeout, busy;
  logic [2:0]  queue_level;
  logic [15:0] jobs_completed;
  int          n_vec = 0, n_err = 0;
  bit          mac_hold = 1'b0, mac_ignore = 1'b0;
  int          mac_busy = 10, mac_cnt = 0;
  logic [TAG_W-1:0] done_q[$];
  typedef struct {
    logic [11:0] in_b, wt_b, res_b;
    logic [3:0]  tag;
    int          busy_c, exp_mv, exp_done;
    logic [15:0] exp_jc;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  mac_job_scheduler_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus();

  mac_job_scheduler #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .err_timeout(err_timeout), .busy(busy),
    .queue_level(queue_level), .jobs_completed(jobs_completed)
  );

  // MAC model: goes busy for mac_busy cycles after accepting a start
  always @(posedge clk) begin
    if (mac_cnt > 1) mac_cnt <= mac_cnt - 1;
    else if (mac_cnt == 1) begin
      mac_cnt       <= 0;
      bus.mac_ready <= 1'b1;
    end else if (mac_hold) bus.mac_ready <= 1'b0;
    else if (bus.mac_valid && bus.mac_ready && !mac_ignore) begin
      bus.mac_ready <= 1'b0;
      mac_cnt       <= mac_busy;
    end else bus.mac_ready <= 1'b1;
  end

  always @(negedge clk) if (reset_n && bus.done_valid) done_q.push_back(bus.done_tag);

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] i, input logic [11:0] w, input logic [11:0] r, input logic [3:0] t);
    int n = 0;
    bit taken = 1'b0;
    bus.job_valid       = 1'b1;
    bus.job_input_base  = i;
    bus.job_weight_base = w;
    bus.job_result_base = r;
    bus.job_tag         = t;
    while (!taken && n < 50) begin
      taken = bus.job_ready;
      tick();
      n++;
    end
    bus.job_valid = 1'b0;
    chk("push_accept", 32'(taken), 32'd1);
  endtask

  function automatic bit sig(input int which);
    return which == 0 ? bus.mac_valid : which == 1 ? bus.done_valid : err_timeout;
  endfunction

  task automatic wait_for(input int which, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sig(which) && n < limit);
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_q.size() < target && n < limit) begin
      tick();
      n++;
    end
    chk("done_count", 32'(done_q.size()), 32'(target));
  endtask

  initial begin
    int n, b, hits, mv_after;
    int rise[8];
    vecs[0] = '{12'h000, 12'h100, 12'h200, 4'h3, 10, 2, 14, 16'd1};
    vecs[1] = '{12'hFFF, 12'hABC, 12'h123, 4'hF, 1, 2, 5, 16'd2};
    vecs[2] = '{12'h555, 12'hAAA, 12'h0F0, 4'h0, 3, 2, 7, 16'd3};
    vecs[3] = '{12'h001, 12'h800, 12'h7FF, 4'h9, 20, 2, 24, 16'd4};
    bus.job_valid = 1'b0;
    bus.job_input_base = '0;
    bus.job_weight_base = '0;
    bus.job_result_base = '0;
    bus.job_tag = '0;
    repeat (3) tick();
    chk("rst_job_ready", 32'(bus.job_ready), 32'd1);
    chk("rst_mac_valid", 32'(bus.mac_valid), 32'd0);
    chk("rst_in_base", 32'(bus.mac_input_base), 32'd0);
    chk("rst_done", 32'(bus.done_valid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(queue_level), 32'd0);
    chk("rst_jc", 32'(jobs_completed), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      mac_busy = vecs[i].busy_c;
      push(vecs[i].in_b, vecs[i].wt_b, vecs[i].res_b, vecs[i].tag);
      wait_for(0, 20, n);
      chk("mv_latency", 32'(n), 32'(vecs[i].exp_mv));
      chk("in_base", 32'(bus.mac_input_base), 32'(vecs[i].in_b));
      chk("wt_base", 32'(bus.mac_weight_base), 32'(vecs[i].wt_b));
      chk("res_base", 32'(bus.mac_result_base), 32'(vecs[i].res_b));
      tick();
      chk("mv_pulse", 32'(bus.mac_valid), 32'd0);
      wait_for(1, 60, n);
      chk("done_delay", 32'(n + 1), 32'(vecs[i].exp_done));
      chk("done_tag", 32'(bus.done_tag), 32'(vecs[i].tag));
      chk("held_res", 32'(bus.mac_result_base), 32'(vecs[i].res_b));
      tick();
      chk("done_pulse", 32'(bus.done_valid), 32'd0);
      chk("jobs_completed", 32'(jobs_completed), 32'(vecs[i].exp_jc));
    end

    // five jobs against a four-deep queue while the MAC is held busy
    b = done_q.size();
    mac_busy = 5;
    mac_hold = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) push(12'(k), 12'(k + 16), 12'(k + 32), 4'(k));
    chk("full_level", 32'(queue_level), 32'd4);
    chk("full_ready", 32'(bus.job_ready), 32'd0);
    bus.job_valid = 1'b1;
    bus.job_tag = 4'd4;
    repeat (2) tick();
    chk("full_hold_level", 32'(queue_level), 32'd4);
    mac_hold = 1'b0;
    push(12'd4, 12'd20, 12'd36, 4'd4);
    wait_done(b + 5, 400);
    for (int k = 0; k < 5; k++) chk("order_tag", 32'(done_q[b + k]), 32'(k));
    tick();
    chk("jc_after_five", 32'(jobs_completed), 32'd9);

    // push and pop on the same edge at level 2
    b = done_q.size();
    mac_hold = 1'b1;
    repeat (2) tick();
    push(12'h150, 12'h151, 12'h152, 4'd5);
    push(12'h160, 12'h161, 12'h162, 4'd6);
    chk("pp_level_before", 32'(queue_level), 32'd2);
    mac_hold = 1'b0;
    tick();
    bus.job_valid = 1'b1;
    bus.job_input_base = 12'h170;
    bus.job_weight_base = 12'h171;
    bus.job_result_base = 12'h172;
    bus.job_tag = 4'd7;
    chk("pp_ready", 32'(bus.job_ready), 32'd1);
    tick();
    bus.job_valid = 1'b0;
    chk("pp_level_after", 32'(queue_level), 32'd2);
    chk("pp_oldest", 32'(bus.mac_input_base), 32'h150);
    wait_done(b + 3, 300);
    for (int k = 0; k < 3; k++) chk("pp_tag", 32'(done_q[b + k]), 32'(k + 5));
    tick();
    chk("jc_after_pp", 32'(jobs_completed), 32'd12);

    // MAC never leaves ready: start is re-issued every five cycles
    b = done_q.size();
    mac_ignore = 1'b1;
    hits = 0;
    push(12'h200, 12'h201, 12'h202, 4'd8);
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.mac_valid) begin
        if (hits < 8) rise[hits] = t;
        hits++;
      end
    end
    chk("retry_hits", 32'(hits), 32'd4);
    chk("retry_first", 32'(rise[0]), 32'd2);
    chk("retry_gap1", 32'(rise[1] - rise[0]), 32'd5);
    chk("retry_gap3", 32'(rise[3] - rise[2]), 32'd5);
    chk("retry_no_done", 32'(done_q.size()), 32'(b));
    mac_ignore = 1'b0;
    wait_done(b + 1, 100);
    chk("retry_tag", 32'(done_q[b]), 32'd8);
    tick();
    chk("jc_after_retry", 32'(jobs_completed), 32'd13);

    // watchdog expiry, then the queued job still runs
    b = done_q.size();
    mac_busy = 200;
    push(12'h3A0, 12'h3A1, 12'h3A2, 4'hA);
    push(12'h3B0, 12'h3B1, 12'h3B2, 4'hB);
    wait_for(0, 10, n);
    chk("to_mv_seen", 32'(bus.mac_valid), 32'd1);
    wait_for(2, 150, n);
    chk("to_delay", 32'(n), 32'd103);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_done", 32'(bus.done_valid), 32'd1);
    chk("to_tag", 32'(bus.done_tag), 32'hA);
    mac_busy = 5;
    tick();
    chk("to_jc_unchanged", 32'(jobs_completed), 32'd13);
    wait_done(b + 2, 300);
    chk("to_first_tag", 32'(done_q[b]), 32'hA);
    chk("to_next_tag", 32'(done_q[b + 1]), 32'hB);
    tick();
    chk("to_jc_next", 32'(jobs_completed), 32'd14);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);

    // reset while a job is in WAIT_DONE with two more queued
    mac_busy = 60;
    push(12'h400, 12'h401, 12'h402, 4'hC);
    push(12'h410, 12'h411, 12'h412, 4'hD);
    push(12'h420, 12'h421, 12'h422, 4'hE);
    wait_for(0, 10, n);
    repeat (5) tick();
    chk("mid_level", 32'(queue_level), 32'd2);
    b = done_q.size();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(queue_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mv", 32'(bus.mac_valid), 32'd0);
    chk("mid_rst_base", 32'(bus.mac_input_base), 32'd0);
    chk("mid_rst_done", 32'(bus.done_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.job_ready), 32'd1);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    chk("mid_rst_jc", 32'(jobs_completed), 32'd0);
    tick();
    reset_n = 1'b1;
    mv_after = 0;
    repeat (80) begin
      tick();
      if (bus.mac_valid) mv_after++;
    end
    chk("post_rst_no_done", 32'(done_q.size()), 32'(b));
    chk("post_rst_no_mv", 32'(mv_after), 32'd0);
    chk("post_rst_level", 32'(queue_level), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
